// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed digit scanner: one shared BCD value bus, one-hot digit enables,
// with digit values double-buffered so new values take effect only at a frame boundary.
module disp_scan_ctrl #(
    parameter int N_DIGITS     = 6,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  disp_clk,
    input  logic                  disp_rst_n,
    input  logic                  disp_load,
    input  logic [4*N_DIGITS-1:0] disp_digits_in,
    input  logic [N_DIGITS-1:0]   disp_blank_mask,
    output logic [3:0]            disp_bcd_out,
    output logic [N_DIGITS-1:0]   disp_digit_en,
    output logic                  disp_frame_start,
    output logic                  disp_load_ack
);

    typedef enum logic {S_BLANK, S_SHOW} state_t;

    localparam int MAX_DB = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int MAXV   = (MAX_DB > N_DIGITS) ? MAX_DB : N_DIGITS;
    localparam int CW     = (MAXV > 1) ? $clog2(MAXV) : 1;
    localparam int IW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    // With no anti-ghosting gap every slot starts directly in SHOW.
    localparam state_t SLOT_FIRST = (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;

    state_t                     fsm_q, fsm_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [N_DIGITS-1:0][3:0]   active_q, active_d;
    logic [N_DIGITS-1:0][3:0]   pending_q, pending_d;
    logic                       pend_vld_q, pend_vld_d;
    logic                       ack_q, ack_d;
    logic                       slot_end;
    logic                       commit;

    // NOTE: the digit buffers are reset along with the control state so the display
    // is guaranteed dark (all 4'hF) straight out of reset rather than showing garbage.
    always_ff @(posedge disp_clk or negedge disp_rst_n) begin
        if (!disp_rst_n) begin
            fsm_q      <= SLOT_FIRST;
            idx_q      <= '0;
            cnt_q      <= '0;
            active_q   <= '1;
            pending_q  <= '1;
            pend_vld_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values computed by the combinational next-state block.
            fsm_q      <= fsm_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            ack_q      <= ack_d;
        end
    end

    assign slot_end = (fsm_q == S_SHOW) && (cnt_q == DWELL_LAST);
    assign commit   = slot_end && (idx_q == IDX_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        fsm_d      = fsm_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q + 1'b1;
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;

        if (fsm_q == S_BLANK && cnt_q == BLANK_LAST) begin
            fsm_d = S_SHOW;
            cnt_d = '0;
        end

        if (slot_end) begin
            fsm_d = SLOT_FIRST;
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (disp_load) begin
            pending_d  = disp_digits_in;
            pend_vld_d = 1'b1;
        end

        // A load arriving on the commit edge itself bypasses the pending buffer.
        if (commit) begin
            if (disp_load) begin
                active_d = disp_digits_in;
            end else if (pend_vld_q) begin
                active_d = pending_q;
            end
            if (disp_load || pend_vld_q) begin
                pend_vld_d = 1'b0;
                ack_d      = 1'b1;
            end
        end
    end

    always_comb begin
        disp_digit_en    = '0;
        disp_bcd_out     = 4'hF;
        disp_frame_start = (idx_q == '0) && (cnt_q == '0) && (fsm_q == SLOT_FIRST);
        disp_load_ack    = ack_q;
        if (fsm_q == S_SHOW && !disp_blank_mask[idx_q]) begin
            disp_digit_en = N_DIGITS'(1) << idx_q;
            disp_bcd_out  = active_q[idx_q];
        end
    end

endmodule
